// File: rtl/resize_pipe_pkg.sv
// resize_pipe_pkg: shared per-beat payload type and the width-resize function
// used by resize_pipe. Widths handled up to MAX_W bits.
package resize_pipe_pkg;

    localparam int unsigned MAX_W = 64;

    typedef logic [MAX_W-1:0] wide_t;

    // Payload produced by the resize step, before it is narrowed to OUT_W.
    typedef struct packed {
        logic  ovf;
        wide_t data;
    } beat_t;

    // Resize din (in_w valid bits) to out_w bits. The input is first extended
    // to MAX_W (sign or zero), so widening, equal width and narrowing share one
    // overflow rule: every bit above the kept field must equal the kept sign
    // bit (signed) or be zero (unsigned).
    function automatic beat_t resize_beat(input wide_t       din,
                                          input int unsigned in_w,
                                          input int unsigned out_w,
                                          input logic        sgn,
                                          input logic        sat);
        beat_t r;
        wide_t ext;
        logic  in_msb;
        logic  keep_msb;
        logic  ovf;
        r        = '0;
        ext      = '0;
        in_msb   = 1'b0;
        keep_msb = 1'b0;
        ovf      = 1'b0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i + 1 == in_w) in_msb = din[i];
        end
        for (int unsigned i = 0; i < MAX_W; i++) begin
            ext[i] = (i < in_w) ? din[i] : (sgn & in_msb);
        end
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i + 1 == out_w) keep_msb = ext[i];
        end
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if ((i >= out_w) && (ext[i] != (sgn & keep_msb))) ovf = 1'b1;
        end
        for (int unsigned i = 0; i < MAX_W; i++) begin
            r.data[i] = (i < out_w) ? ext[i] : 1'b0;
        end
        if (sat && ovf) begin
            for (int unsigned i = 0; i < MAX_W; i++) begin
                if (i < out_w) begin
                    if (sgn) r.data[i] = (i + 1 == out_w) ? in_msb : ~in_msb;
                    else     r.data[i] = 1'b1;
                end
            end
        end
        r.ovf = ovf;
        return r;
    endfunction

endpackage

// File: rtl/resize_pipe_stage.sv
// resize_pipe_stage: one valid/ready register slice. Loads when empty or when
// the downstream side takes the current beat in the same cycle.
module resize_pipe_stage #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Ready when the slot is free or is being emptied this cycle.
    always_comb begin
        in_ready = !out_valid || out_ready;
    end

    // Slot register; data only changes on a real load so it holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/resize_pipe.sv
// resize_pipe: resizes IN_W-bit beats to OUT_W bits (sign/zero extend,
// truncate, optional saturate) and carries them through DEPTH register slices.
// Saturation on narrowing is built only when RESIZE_PIPE_SAT_EN is defined;
// otherwise in_sat is ignored and narrowing always truncates.
module resize_pipe
    import resize_pipe_pkg::*;
#(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 3,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_cnt
);

    wide_t din_w;
    beat_t rb;
    logic  sat_eff;
    logic  unused_bits;

`ifdef RESIZE_PIPE_SAT_EN
    // Saturation request passes straight through.
    always_comb begin
        sat_eff = in_sat;
    end
`else
    logic unused_sat;

    // Saturation not built: always truncate.
    always_comb begin
        sat_eff    = 1'b0;
        unused_sat = in_sat;
    end
`endif

    // Place the input in the low bits of the wide working value.
    always_comb begin
        din_w             = '0;
        din_w[IN_W-1:0]   = in_data;
    end

    // Combinational resize ahead of stage 0.
    always_comb begin
        rb          = resize_beat(din_w, IN_W, OUT_W, in_signed, sat_eff);
        unused_bits = ^rb.data;
    end

    logic [DEPTH:0] v;
    logic [DEPTH:0] r;
    logic [OUT_W:0] d [DEPTH+1];

    assign v[0]     = in_valid;
    assign d[0]     = {rb.ovf, rb.data[OUT_W-1:0]};
    assign in_ready = r[0];
    assign r[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        resize_pipe_stage #(.W(OUT_W + 1)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v[k]),
            .in_ready  (r[k]),
            .in_data   (d[k]),
            .out_valid (v[k+1]),
            .out_ready (r[k+1]),
            .out_data  (d[k+1])
        );
    end

    assign out_valid          = v[DEPTH];
    assign {out_ovf, out_data} = d[DEPTH];

    // Count delivered overflow beats, holding at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (out_valid && out_ready && out_ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule
